wb_pattern_master: RTL and testbench

- Synthesizable Wishbone B3 master that sits directly upstream of the SDRAM controller's Wishbone slave port.
- Accepts burst commands (address, length, direction, seed) from the test sequencer over a valid/ready handshake.
- Drives incrementing-address bursts with a deterministic data pattern.
- On reads, checks returned data against the same pattern and accumulates an error count, so self-checking traffic runs at bus rate.

---
 rtl/wb_pm_pkg.sv | 23 ++
 rtl/wb_pm_pattern_gen.sv | 55 +++++
 rtl/wb_pattern_master.sv | 191 +++++++++++++++++++
 tb/tb_wb_pattern_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pm_pkg.sv
// Shared types for the Wishbone pattern master: FSM states and cycle-type codes.
// Pure declarations, no logic, no latency.
package wb_pm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        END  = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Cycle type for one beat: classic for single-beat bursts, end-of-burst on the last beat.
    function automatic logic [2:0] beat_cti(input logic is_single, input logic is_last);
        if (is_single) begin
            return CTI_CLASSIC;
        end
        return is_last ? CTI_EOB : CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_pm_pattern_gen.sv
// Burst pattern state: seed, beat counter and address; expected data and next-beat values.
// Outputs are combinational from its registers; loads/advances take effect on the next edge.
module wb_pm_pattern_gen
    import wb_pm_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 26,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic [AW-1:0]    i_addr,
    input  logic [LEN_W-1:0] i_len,
    input  logic [DW-1:0]    i_seed,
    output logic [DW-1:0]    o_exp_dat,
    output logic [DW-1:0]    o_nxt_dat,
    output logic [AW-1:0]    o_nxt_addr,
    output logic             o_last,
    output logic             o_nxt_last
);

    logic [DW-1:0]    r_seed;
    logic [LEN_W-1:0] r_k;
    logic [LEN_W-1:0] r_len;
    logic [AW-1:0]    r_addr;
    logic [LEN_W:0]   w_k_inc;

    assign w_k_inc    = {1'b0, r_k} + {{LEN_W{1'b0}}, 1'b1};
    assign o_exp_dat  = r_seed + DW'(r_k);
    assign o_nxt_dat  = r_seed + DW'(w_k_inc);
    // Address arithmetic is AW bits wide, so a burst crossing the top wraps to zero.
    assign o_nxt_addr = r_addr + AW'(DW / 8);
    assign o_last     = (r_k == r_len);
    assign o_nxt_last = (w_k_inc == {1'b0, r_len});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed <= '0;
            r_k    <= '0;
            r_len  <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_seed <= i_seed;
            r_k    <= '0;
            r_len  <= i_len;
            r_addr <= i_addr;
        end else if (i_adv) begin
            r_k    <= w_k_inc[LEN_W-1:0];
            r_addr <= o_nxt_addr;
        end
    end

endmodule

// File: rtl/wb_pattern_master.sv
// Wishbone B3 burst master generating seed+k data; read bursts are checked and errors counted.
// One beat per acked cycle; slave backpressure by withholding ack, bounded by the TIMEOUT watchdog.
module wb_pattern_master
    import wb_pm_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 26,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              sys_clk,
    input  logic              RESETN,
    input  logic              sdr_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DW-1:0]     cmd_seed,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    input  logic              err_clr,
    output logic [31:0]       err_cnt
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic [DW/8-1:0]   r_sel;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_dat;
    logic [2:0]        r_cti;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic [31:0]       r_err_cnt;
    logic [WD_W-1:0]   r_wdog;

    logic              w_accept;
    logic              w_ack;
    logic              w_adv;
    logic              w_mismatch;
    logic              w_to_evt;
    logic [DW-1:0]     w_exp_dat;
    logic [DW-1:0]     w_nxt_dat;
    logic [AW-1:0]     w_nxt_addr;
    logic              w_last;
    logic              w_nxt_last;

    assign cmd_ready  = (r_state == IDLE) && sdr_init_done;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_ack      = (r_state == BUS) && wb_ack_i;
    assign w_adv      = w_ack && !w_last;
    assign w_mismatch = w_ack && !r_we && (wb_dat_i != w_exp_dat);
    assign w_to_evt   = (r_state == BUS) && !wb_ack_i && (r_wdog == WD_LAST);

    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_stb;
    assign wb_we_o   = r_we;
    assign wb_addr_o = r_addr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign wb_cti_o  = r_cti;
    assign busy      = r_busy;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign err_cnt   = r_err_cnt;

    wb_pm_pattern_gen #(
        .DW    (DW),
        .AW    (AW),
        .LEN_W (LEN_W)
    ) u_pattern_gen (
        .clk        (sys_clk),
        .rst_n      (RESETN),
        .i_load     (w_accept),
        .i_adv      (w_adv),
        .i_addr     (cmd_addr),
        .i_len      (cmd_len),
        .i_seed     (cmd_seed),
        .o_exp_dat  (w_exp_dat),
        .o_nxt_dat  (w_nxt_dat),
        .o_nxt_addr (w_nxt_addr),
        .o_last     (w_last),
        .o_nxt_last (w_nxt_last)
    );

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            r_state   <= IDLE;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_addr    <= '0;
            r_dat     <= '0;
            r_cti     <= CTI_CLASSIC;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_err_cnt <= '0;
            r_wdog    <= '0;
        end else begin
            r_done <= 1'b0;
            r_sel  <= '1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= BUS;
                        r_busy  <= 1'b1;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= cmd_we;
                        r_addr  <= cmd_addr;
                        r_dat   <= cmd_we ? cmd_seed : '0;
                        r_cti   <= beat_cti(cmd_len == '0, cmd_len == '0);
                        r_wdog  <= '0;
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        r_wdog <= '0;
                        if (w_last) begin
                            r_state <= END;
                            r_done  <= 1'b1;
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_we    <= 1'b0;
                            r_addr  <= '0;
                            r_dat   <= '0;
                            r_cti   <= CTI_CLASSIC;
                        end else begin
                            r_addr <= w_nxt_addr;
                            r_dat  <= r_we ? w_nxt_dat : '0;
                            r_cti  <= beat_cti(1'b0, w_nxt_last);
                        end
                    end else if (w_to_evt) begin
                        // Abandon the remaining beats but still finish through END so done pulses.
                        r_state <= END;
                        r_done  <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_dat   <= '0;
                        r_cti   <= CTI_CLASSIC;
                        r_wdog  <= '0;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                END: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Clear wins over a same-cycle mismatch or timeout; that event is dropped.
            if (err_clr) begin
                r_err_cnt <= '0;
                r_timeout <= 1'b0;
            end else begin
                if (w_to_evt) begin
                    r_timeout <= 1'b1;
                end
                if ((w_mismatch || w_to_evt) && (r_err_cnt != 32'hFFFF_FFFF)) begin
                    r_err_cnt <= r_err_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_pattern_master.sv
// Directed bench for wb_pattern_master: expected beats queued at command time, checked per beat.
// Slave behaviour (ack timing, corrupted read data) is scripted in the main sequence.
module tb_wb_pattern_master;

    localparam int DW    = 32;
    localparam int AW    = 26;
    localparam int LEN_W = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [2:0]    cti;
        logic          we;
    } beat_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              init_done;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [AW-1:0]     cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DW-1:0]     cmd_seed;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [AW-1:0]     wb_addr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic              wb_ack_i;
    logic [DW-1:0]     wb_dat_i;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              err_clr;
    logic [31:0]       err_cnt;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    wb_pattern_master #(
        .DW      (DW),
        .AW      (AW),
        .LEN_W   (LEN_W),
        .TIMEOUT (16)
    ) dut (
        .sys_clk       (clk),
        .RESETN        (rstn),
        .sdr_init_done (init_done),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_seed      (cmd_seed),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_addr_o     (wb_addr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_cti_o      (wb_cti_o),
        .wb_ack_i      (wb_ack_i),
        .wb_dat_i      (wb_dat_i),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .err_clr       (err_clr),
        .err_cnt       (err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a command from a negedge; returns at the negedge after acceptance.
    task automatic issue_cmd(input logic we, input logic [AW-1:0] a, input logic [LEN_W-1:0] len,
                             input logic [DW-1:0] seed);
        int n;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_seed  = seed;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic burst(input logic we, input logic [AW-1:0] a, input logic [LEN_W-1:0] len,
                         input logic [DW-1:0] seed, input int bad_beat, input int dly);
        beat_t e;
        for (int k = 0; k <= int'(len); k++) begin
            e.addr = a + AW'(4 * k);
            e.dat  = seed + DW'(k);
            e.cti  = (len == 0) ? 3'b000 : (k == int'(len)) ? 3'b111 : 3'b010;
            e.we   = we;
            exp_q.push_back(e);
        end
        issue_cmd(we, a, len, seed);
        for (int k = 0; k <= int'(len); k++) begin
            e = exp_q.pop_front();
            chk("cyc", wb_cyc_o, 1);
            chk("stb", wb_stb_o, 1);
            chk("we", wb_we_o, e.we);
            chk("addr", wb_addr_o, e.addr);
            chk("wdat", wb_dat_o, e.we ? e.dat : 32'h0);
            chk("cti", wb_cti_o, e.cti);
            chk("sel", wb_sel_o, 4'hF);
            if (dly > 0) begin
                wb_ack_i = 1'b0;
                for (int d = 0; d < dly; d++) begin
                    @(negedge clk);
                    chk("hold_cyc", wb_cyc_o, 1);
                    chk("hold_stb", wb_stb_o, 1);
                    chk("hold_addr", wb_addr_o, e.addr);
                end
            end
            wb_ack_i = 1'b1;
            wb_dat_i = e.we ? 32'h0 : (k == bad_beat) ? 32'hDEAD_BEEF : e.dat;
            @(negedge clk);
        end
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        chk("cyc_end", wb_cyc_o, 0);
        chk("stb_end", wb_stb_o, 0);
        chk("done_pulse", done, 1);
        chk("busy_in_end", busy, 1);
        @(negedge clk);
        chk("done_once", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int n;
        rstn      = 1'b0;
        init_done = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_seed  = '0;
        wb_ack_i  = 1'b0;
        wb_dat_i  = '0;
        err_clr   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_cti", wb_cti_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rstn      = 1'b1;
        init_done = 1'b1;
        @(negedge clk);

        // Write then read-back, clean and with one corrupted beat.
        burst(1'b1, 26'h100, 8'd3, 32'hA5A5_0000, -1, 0);
        burst(1'b0, 26'h100, 8'd3, 32'hA5A5_0000, -1, 0);
        chk("err_after_clean_read", err_cnt, 0);
        burst(1'b0, 26'h100, 8'd3, 32'hA5A5_0000, 2, 0);
        chk("err_after_bad_beat", err_cnt, 1);

        burst(1'b0, 26'h080, 8'd0, 32'h0000_1111, -1, 0);
        burst(1'b0, 26'h084, 8'd0, 32'h0000_2222, -1, 5);
        chk("err_after_singles", err_cnt, 1);
        chk("timeout_still_clear", timeout, 0);

        // Slave never acks: watchdog aborts after 16 BUS cycles.
        issue_cmd(1'b0, 26'h200, 8'd3, 32'h1234_0000);
        n = 0;
        while (wb_cyc_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_stb", wb_stb_o, 0);
        chk("timeout_done", done, 1);
        chk("timeout_flag", timeout, 1);
        chk("timeout_err_cnt", err_cnt, 2);
        @(negedge clk);
        chk("timeout_busy_idle", busy, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_timeout", timeout, 0);

        // Commands held off while SDRAM init is incomplete.
        init_done = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 26'h300;
        cmd_len   = 8'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("gated_ready", cmd_ready, 0);
            chk("gated_cyc", wb_cyc_o, 0);
        end
        cmd_valid = 1'b0;
        init_done = 1'b1;
        @(negedge clk);

        burst(1'b1, 26'h3FF_FFFC, 8'd1, 32'hCAFE_0000, -1, 0);

        // Reset lands on beat 1 of a 4-beat write.
        issue_cmd(1'b1, 26'h040, 8'd3, 32'h5555_0000);
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk("pre_reset_addr", wb_addr_o, 26'h044);
        rstn = 1'b0;
        #1;
        chk("async_rst_cyc", wb_cyc_o, 0);
        chk("async_rst_stb", wb_stb_o, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", cmd_ready, 1);
        chk("post_reset_cyc", wb_cyc_o, 0);
        burst(1'b1, 26'h040, 8'd3, 32'h5555_0000, -1, 0);
        chk("post_reset_err_cnt", err_cnt, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
